// File: rtl/stack_frame_engine_pkg.sv
// Shared definitions for the stack frame engine: transfer direction and FSM states.
package stack_frame_engine_pkg;

  localparam logic PUSH = 1'b0;
  localparam logic POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/stack_frame_engine.sv
// Moves a multi-word frame between the controller and the downward-growing data-memory stack,
// one bus grant per word, tracking SP and flagging overflow/underflow.
//
// state | meaning
// IDLE  | waiting for start or debug SP load
// XFER  | one word per granted bus cycle
// DONE  | one-cycle completion pulse, err valid
module stack_frame_engine
  import stack_frame_engine_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                FRAME_WORDS = 2,
  parameter logic [ADDR_W-1:0] STACK_BASE  = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          push_or_pop,
  input  logic [FRAME_WORDS*DATA_W-1:0] frame_din,
  output logic [FRAME_WORDS*DATA_W-1:0] frame_dout,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [ADDR_W-1:0]             sp,
  input  logic                          sp_wr,
  input  logic [ADDR_W-1:0]             sp_din,
  output logic                          bus_req,
  input  logic                          bus_grant,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_wr,
  output logic                          mem_rd,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int EXT_W = ADDR_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);
  // Widened so the limit checks cannot wrap even after an odd debug SP load.
  localparam logic [EXT_W-1:0] PUSH_MIN_SP = EXT_W'(STACK_LIMIT) + EXT_W'(FRAME_WORDS) - EXT_W'(1);
  localparam logic [EXT_W-1:0] BASE_EXT    = EXT_W'(STACK_BASE);
  localparam logic [EXT_W-1:0] FW_EXT      = EXT_W'(FRAME_WORDS);

  state_t                        state, state_nx;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W-1:0]              pop_idx;
  logic                          dir_q;
  logic [FRAME_WORDS*DATA_W-1:0] frame_q;
  logic [EXT_W-1:0]              sp_ext;
  logic                          push_ok, pop_ok, accept_ok, take_start;

  assign sp_ext     = {2'b00, sp};
  assign push_ok    = sp_ext >= PUSH_MIN_SP;
  assign pop_ok     = (sp_ext + FW_EXT) <= BASE_EXT;
  assign accept_ok  = (push_or_pop == PUSH) ? push_ok : pop_ok;
  assign take_start = (state == ST_IDLE) && !sp_wr && start;
  // Pops return the top-most word first, i.e. the highest frame index.
  assign pop_idx    = LAST_CNT - cnt;

  always_comb begin
    state_nx  = state;
    bus_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take_start) state_nx = accept_ok ? ST_XFER : ST_DONE;
      end
      ST_XFER: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (dir_q == PUSH) begin
          mem_wr   = 1'b1;
          mem_addr = sp;
          for (int k = 0; k < FRAME_WORDS; k++) begin
            if (cnt == CNT_W'(k)) mem_wdata = frame_q[k*DATA_W +: DATA_W];
          end
        end else begin
          mem_rd   = 1'b1;
          mem_addr = sp + 1'b1;
        end
        if (bus_grant && cnt == LAST_CNT) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sp         <= STACK_BASE;
      cnt        <= '0;
      dir_q      <= PUSH;
      frame_q    <= '0;
      frame_dout <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (sp_wr) begin
            sp <= sp_din;
          end else if (start) begin
            err   <= !accept_ok;
            dir_q <= push_or_pop;
            cnt   <= '0;
            if (push_or_pop == PUSH) frame_q <= frame_din;
          end
        end
        ST_XFER: begin
          if (bus_grant) begin
            cnt <= cnt + 1'b1;
            if (dir_q == PUSH) begin
              sp <= sp - 1'b1;
            end else begin
              sp <= sp + 1'b1;
              for (int k = 0; k < FRAME_WORDS; k++) begin
                if (pop_idx == CNT_W'(k)) frame_dout[k*DATA_W +: DATA_W] <= mem_rdata;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
